// File: rtl/ravenna_dac_pkg.sv
// Shared types and defaults for the Ravenna DAC sample sequencer.
// Pure declarations: no latency, no flow control.
package ravenna_dac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POWERUP = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int DEF_DAC_BITS      = 10;
  localparam int DEF_FIFO_DEPTH    = 8;
  localparam int DEF_DIV_BITS      = 16;
  localparam int DEF_SETTLE_CYCLES = 64;

  // Level counter needs one extra bit so that "full" (== depth) is representable.
  function automatic int level_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ravenna_dac_fifo.sv
// Synchronous sample FIFO with flush; head is read combinationally, push/pop take effect at the edge.
// Backpressure: full refuses pushes internally, pop on empty is ignored, flush overrides both.
module ravenna_dac_fifo
  import ravenna_dac_pkg::*;
#(
  parameter int WIDTH = DEF_DAC_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              head,
  output logic [level_bits(DEPTH)-1:0]  level,
  output logic                          full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_bits(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == DEPTH_L);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (level != '0) && !flush;

  // Storage needs no reset; the level counter guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ravenna_dac_sequencer.sv
// DAC sample sequencer: settle after enable, then one FIFO sample per clkdiv+1 cycles (value one edge after tick).
// Backpressure: s_ready drops when the FIFO is full or while a disable flush is in progress.
module ravenna_dac_sequencer
  import ravenna_dac_pkg::*;
#(
  parameter int DAC_BITS      = DEF_DAC_BITS,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int DIV_BITS      = DEF_DIV_BITS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               enable,
  input  logic [DIV_BITS-1:0]                clkdiv,
  input  logic                               hold_last,
  input  logic                               s_valid,
  input  logic [DAC_BITS-1:0]                s_data,
  output logic                               s_ready,
  output logic                               dac_ena,
  output logic [DAC_BITS-1:0]                dac_value,
  output logic                               dac_strobe,
  output logic [level_bits(FIFO_DEPTH)-1:0]  fifo_level,
  output logic                               underrun,
  input  logic                               underrun_clr,
  output logic                               busy
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [SW-1:0]       settle_cnt;
  logic [DIV_BITS-1:0] div_cnt;
  logic                flush;
  logic                tick;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push_vld;
  logic                pop_vld;
  logic [DAC_BITS-1:0] fifo_head;

  // Dropping enable while active tears everything down in a single edge.
  assign flush      = (state != IDLE) && !enable;
  assign tick       = (state == RUN) && enable && (div_cnt == '0);
  assign fifo_empty = (fifo_level == '0);
  assign pop_vld    = tick && !fifo_empty;
  assign s_ready    = !fifo_full && !flush;
  assign push_vld   = s_valid && s_ready;

  ravenna_dac_fifo #(
    .WIDTH (DAC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_vld),
    .push_data (s_data),
    .pop       (pop_vld),
    .flush     (flush),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // dac_ena decodes straight from the state register so reset drops it without a clock.
  always_comb begin
    state_nxt = state;
    dac_ena   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = POWERUP;
      end
      POWERUP: begin
        dac_ena = 1'b1;
        busy    = 1'b1;
        if (!enable)                state_nxt = IDLE;
        else if (settle_cnt == '0)  state_nxt = RUN;
      end
      RUN: begin
        dac_ena = 1'b1;
        busy    = 1'b1;
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      settle_cnt <= '0;
      div_cnt    <= '0;
    end else begin
      if (state == IDLE && enable) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (state == POWERUP && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SW'(1);
      end

      // Divider starts at zero so the first RUN cycle is already a tick.
      if (state == POWERUP && settle_cnt == '0) begin
        div_cnt <= '0;
      end else if (state == RUN) begin
        if (div_cnt == '0) div_cnt <= clkdiv;
        else               div_cnt <= div_cnt - DIV_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dac_value  <= '0;
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dac_strobe <= pop_vld;

      if (flush)                   dac_value <= '0;
      else if (pop_vld)            dac_value <= fifo_head;
      else if (tick && !hold_last) dac_value <= '0;

      // A new underrun outranks a simultaneous clear.
      if (tick && fifo_empty) underrun <= 1'b1;
      else if (underrun_clr)  underrun <= 1'b0;
    end
  end

endmodule
